// File: rtl/keypad_matrix_scanner.sv
// 4x4 membrane keypad scanner: drives one active-low row at a time, snapshots
// the synchronized columns into a 16-bit frame, and debounces whole frames into key events.
module keypad_matrix_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] kp_col,
  output logic [3:0] kp_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  logic [3:0]       col_meta_q, col_meta_d;
  logic [3:0]       col_sync_q, col_sync_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0][3:0]  snap_q, snap_d;
  logic             frame_valid_q, frame_valid_d;
  logic             row_tick;

  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             multi_key_q, multi_key_d;

  logic [15:0]      snap_bits;
  logic [4:0]       key_count;
  logic [3:0]       single_code;
  logic             is_none, is_single, is_multi;

  // Row scan timing: the last dwell cycle samples the row and advances to the next.
  always_comb begin
    col_meta_d    = kp_col;
    col_sync_d    = col_meta_q;
    row_tick      = (div_q == DIV_LAST);
    div_d         = row_tick ? '0 : div_q + 1'b1;
    row_idx_d     = row_tick ? row_idx_q + 2'd1 : row_idx_q;
    frame_valid_d = row_tick && (row_idx_q == 2'd3);
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      assign kp_row[gi] = ~(row_idx_q == 2'(gi));
      // Columns are pulled up, so a low column means that key is pressed.
      assign snap_d[gi] = (row_tick && (row_idx_q == 2'(gi))) ? ~col_sync_q : snap_q[gi];
    end
  endgenerate

  assign snap_bits = snap_q;

  // Frame classification; single_code is only meaningful when exactly one bit is set.
  always_comb begin
    key_count   = '0;
    single_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_bits[i]) begin
        key_count   = key_count + 5'd1;
        single_code = 4'(i);
      end
    end
    is_none   = (key_count == 5'd0);
    is_single = (key_count == 5'd1);
    is_multi  = (key_count > 5'd1);
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_key_d = multi_key_q;
    cnt_inc     = cnt_q + 1'b1;

    if (frame_valid_q) begin
      multi_key_d = is_multi;
      case (state_q)
        IDLE: begin
          if (is_single) begin
            state_d = DEBOUNCE;
            cand_d  = single_code;
            cnt_d   = CNT_W'(1);
          end
        end
        DEBOUNCE: begin
          if (is_single && (single_code == cand_q)) begin
            if (cnt_inc == CNT_DONE) begin
              state_d     = PRESSED;
              cnt_d       = '0;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (is_single) begin
            cand_d = single_code;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          // Held keys never auto-repeat; only a clean release re-arms detection.
          if (is_none) begin
            state_d = RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE: begin
          if (is_none) begin
            if (cnt_inc == CNT_DONE) begin
              state_d    = IDLE;
              cnt_d      = '0;
              key_held_d = 1'b0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = PRESSED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q    <= 4'hF;
      col_sync_q    <= 4'hF;
      div_q         <= '0;
      row_idx_q     <= '0;
      snap_q        <= '0;
      frame_valid_q <= 1'b0;
      state_q       <= IDLE;
      cand_q        <= '0;
      cnt_q         <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      multi_key_q   <= 1'b0;
    end else begin
      col_meta_q    <= col_meta_d;
      col_sync_q    <= col_sync_d;
      div_q         <= div_d;
      row_idx_q     <= row_idx_d;
      snap_q        <= snap_d;
      frame_valid_q <= frame_valid_d;
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_held_q    <= key_held_d;
      multi_key_q   <= multi_key_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a keypad pin model, frame-aligned directed vectors,
// and randomized frames checked against a run-length reference model.
module tb_keypad_matrix_scanner;
  localparam int DIV   = 8;
  localparam int NDB   = 3;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  kp_col;
  logic [3:0]  kp_row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        multi_key;
  logic [15:0] keys = '0;

  always #5 clk = ~clk;

  // A pressed key shorts its column low only while its row is driven low.
  always_comb begin
    kp_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp_row[r]) kp_col[c] = 1'b0;
  end

  keypad_matrix_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_SCANS(NDB)) dut (
    .clk(clk), .rst(rst), .kp_col(kp_col), .kp_row(kp_row),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .multi_key(multi_key)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ticks_left = FRAME;
  int frame_no = 0;
  int pulses_seen = 0;
  int pulses_exp = 0;
  int consec = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (key_valid) begin
      pulses_seen <= pulses_seen + 1;
      if (prev_valid) consec <= consec + 1;
    end
    prev_valid <= key_valid;
  end

  // Reference model: acceptance = N identical single-key frames in a row while not held;
  // release = N empty frames in a row while held.
  bit         m_held;
  int         m_run, m_none;
  logic [3:0] m_run_code, m_code;
  logic       m_valid, m_multi;

  task automatic model_reset();
    m_held = 0; m_run = 0; m_none = 0; m_run_code = '0; m_code = '0;
    m_valid = 0; m_multi = 0;
  endtask

  task automatic model_frame(input logic [15:0] k);
    int n;
    logic [3:0] c;
    n = $countones(k);
    c = '0;
    for (int i = 0; i < 16; i++) if (k[i]) c = i[3:0];
    m_valid = 0;
    m_multi = (n >= 2);
    if (n == 1) begin
      if (m_run > 0 && m_run_code == c) m_run++;
      else begin m_run = 1; m_run_code = c; end
      m_none = 0;
    end else if (n == 0) begin
      m_none++;
      m_run = 0;
    end else begin
      m_run = 0;
      m_none = 0;
    end
    if (!m_held && n == 1 && m_run == NDB) begin
      m_valid = 1; m_code = c; m_held = 1;
    end else if (m_held && n == 0 && m_none == NDB) begin
      m_held = 0;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (frame %0d cyc %0d)", name, act, exp, frame_no, cyc);
    end
  endtask

  task automatic tick();
    logic r;
    logic [3:0] exp_row;
    r = rst;
    @(posedge clk);
    #1;
    if (r) cyc = 0; else cyc++;
    exp_row = ~(4'b0001 << ((cyc / DIV) % 4));
    check("kp_row", int'(kp_row), int'(exp_row));
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [3:0] ec,
                            input logic eh, input logic em);
    check({tag, "_key_valid"}, int'(key_valid), int'(ev));
    check({tag, "_key_code"},  int'(key_code),  int'(ec));
    check({tag, "_key_held"},  int'(key_held),  int'(eh));
    check({tag, "_multi_key"}, int'(multi_key), int'(em));
  endtask

  // Apply one full frame of keys; returns just after the FSM edge that evaluates it.
  task automatic do_frame(input logic [15:0] k);
    keys = k;
    repeat (ticks_left) tick();
    model_frame(k);
    tick();
    ticks_left = FRAME - 1;
    if (m_valid) pulses_exp++;
    frame_no++;
    $display("frame %0d keys=%h valid=%0d code=%0d held=%0d multi=%0d",
             frame_no, k, key_valid, key_code, key_held, multi_key);
  endtask

  typedef struct {
    logic [15:0] keys;
    int          reps;
    logic        v;
    logic [3:0]  c;
    logic        h;
    logic        m;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [15:0] k, input int reps, input logic v,
                              input logic [3:0] c, input logic h, input logic m);
    vec_t t;
    t.keys = k; t.reps = reps; t.v = v; t.c = c; t.h = h; t.m = m;
    return t;
  endfunction

  initial begin
    logic [3:0]  fav;
    logic [15:0] k;
    int          sel, a, b;

    // idle, press 9, release/re-press, bounce 3, multi 0+5 then 5
    tbl.push_back(mk(16'h0000, 2,  0, 4'd0, 0, 0));
    tbl.push_back(mk(16'h0200, 2,  0, 4'd0, 0, 0));
    tbl.push_back(mk(16'h0200, 1,  1, 4'd9, 1, 0));
    tbl.push_back(mk(16'h0200, 10, 0, 4'd9, 1, 0));
    tbl.push_back(mk(16'h0000, 1,  0, 4'd9, 1, 0));
    tbl.push_back(mk(16'h0200, 1,  0, 4'd9, 1, 0));
    tbl.push_back(mk(16'h0000, 2,  0, 4'd9, 1, 0));
    tbl.push_back(mk(16'h0000, 1,  0, 4'd9, 0, 0));
    tbl.push_back(mk(16'h0200, 2,  0, 4'd9, 0, 0));
    tbl.push_back(mk(16'h0200, 1,  1, 4'd9, 1, 0));
    tbl.push_back(mk(16'h0000, 2,  0, 4'd9, 1, 0));
    tbl.push_back(mk(16'h0000, 1,  0, 4'd9, 0, 0));
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mk(16'h0008, 1, 0, 4'd9, 0, 0));
      tbl.push_back(mk(16'h0000, 1, 0, 4'd9, 0, 0));
    end
    tbl.push_back(mk(16'h0021, 4,  0, 4'd9, 0, 1));
    tbl.push_back(mk(16'h0020, 2,  0, 4'd9, 0, 0));
    tbl.push_back(mk(16'h0020, 1,  1, 4'd5, 1, 0));
    tbl.push_back(mk(16'h0000, 2,  0, 4'd5, 1, 0));
    tbl.push_back(mk(16'h0000, 1,  0, 4'd5, 0, 0));

    model_reset();
    rst = 1'b1;
    keys = '0;
    tick();
    tick();
    check_outs("reset", 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    ticks_left = FRAME;

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        do_frame(tbl[i].keys);
        check_outs($sformatf("vec%0d", i), tbl[i].v, tbl[i].c, tbl[i].h, tbl[i].m);
      end
    end

    // Reset in the middle of a debounce: acceptance must restart from scratch.
    do_frame(16'h4000);
    check_outs("pre_rst1", 1'b0, 4'd5, 1'b0, 1'b0);
    do_frame(16'h4000);
    check_outs("pre_rst2", 1'b0, 4'd5, 1'b0, 1'b0);
    keys = 16'h4000;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    ticks_left = FRAME;
    check_outs("mid_rst", 1'b0, 4'd0, 1'b0, 1'b0);
    check("mid_rst_kp_row", int'(kp_row), 14);
    do_frame(16'h4000);
    check_outs("post_rst1", 1'b0, 4'd0, 1'b0, 1'b0);
    do_frame(16'h4000);
    check_outs("post_rst2", 1'b0, 4'd0, 1'b0, 1'b0);
    do_frame(16'h4000);
    check_outs("post_rst3", 1'b1, 4'd14, 1'b1, 1'b0);
    do_frame(16'h0000);
    do_frame(16'h0000);
    do_frame(16'h0000);
    check_outs("post_rst_rel", 1'b0, 4'd14, 1'b0, 1'b0);

    // Randomized frames against the reference model.
    fav = 4'($urandom_range(0, 15));
    for (int f = 0; f < 80; f++) begin
      sel = $urandom_range(0, 9);
      k = '0;
      if (sel <= 1) k = '0;
      else if (sel <= 6) k[fav] = 1'b1;
      else if (sel == 7) k[$urandom_range(0, 15)] = 1'b1;
      else if (sel == 8) begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        k[a] = 1'b1;
        k[b] = 1'b1;
      end else begin
        fav = 4'($urandom_range(0, 15));
        k[fav] = 1'b1;
      end
      do_frame(k);
      check_outs("rand", m_valid, m_code, m_held, m_multi);
    end

    repeat (4) tick();
    check("pulse_count", pulses_seen, pulses_exp);
    check("consecutive_valid", consec, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Scans a 4x4 membrane keypad by driving rows and reading columns. This is the input-direction counterpart of the LED dot-matrix row/column scan drivers.
- Debounces whole-frame snapshots and emits one key code per press, plus a one-cycle valid pulse.
- Sits between the board keypad pins and game/control logic. It replaces ad-hoc per-button pulse stretchers for multi-key input.

Parameters:
- SCAN_DIV, 50000: clock cycles each row is driven (dwell); minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full frames required to accept a press or a release; minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- kp_col  input  4  keypad columns, active-low (pulled up), bit0 = column 0; asynchronous to clk
- kp_row  output  4  keypad row drive, active-low one-hot, bit0 = row 0
- key_code  output  4  accepted key = row*4 + col; held until next accepted press
- key_valid  output  1  one-cycle pulse when a new key_code is accepted
- key_held  output  1  high while an accepted key remains pressed (until debounced release)
- multi_key  output  1  high when the last completed frame had more than one key pressed

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all state updates on the posedge clk where rst=1.
- Reset values:
  - kp_row=4'b1110; key_code=0; key_valid=0; key_held=0; multi_key=0.
  - Column synchronizer=4'b1111; div counter=0; row index=0; snapshot=0; FSM=IDLE; debounce counter=0.
- Synchronizer: kp_col passes through a 2-flop synchronizer. Only the synchronized value is used.
- Scan timing:
  - The div counter counts 0..SCAN_DIV-1.
  - When the count is SCAN_DIV-1, the synchronized columns are sampled into 4 snapshot bits for the current row (pressed = bit 0 inverted to 1).
  - On that same edge, the row index advances (3 wraps to 0) and kp_row updates.
  - Each row is therefore driven exactly SCAN_DIV cycles; one frame = 4*SCAN_DIV cycles.
- Frame end: the row-3 sample completes the 16-bit snapshot. A frame-valid strobe is raised on the following edge. The FSM and multi_key update on that strobe.
- Per-frame classification: count of set snapshot bits:
  - 0 → NONE
  - 1 → SINGLE(code)
  - ≥2 → MULTI
  - multi_key = (class==MULTI), updated every frame.
- FSM states IDLE, DEBOUNCE, PRESSED, RELEASE, evaluated once per frame:
  - IDLE: SINGLE(c) → DEBOUNCE with cand=c, cnt=1. Otherwise stay.
  - DEBOUNCE:
    - SINGLE(cand) → cnt+1. When cnt+1==DEBOUNCE_SCANS → PRESSED, key_code=cand, key_valid=1 for exactly one cycle, key_held=1.
    - SINGLE(other) → restart, cand=other, cnt=1.
    - NONE or MULTI → IDLE.
  - PRESSED: NONE → RELEASE, cnt=1. SINGLE or MULTI → stay; no auto-repeat, no new key_valid.
  - RELEASE:
    - NONE → cnt+1. When cnt+1==DEBOUNCE_SCANS → IDLE, key_held=0.
    - Any pressed frame → PRESSED; key_held stays 1, no pulse.
- Boundary behaviour:
  - key_valid is never high two consecutive cycles.
  - A press shorter than DEBOUNCE_SCANS frames is ignored.
  - A new key pressed while another is held produces nothing until full debounced release.
  - Press acceptance latency: DEBOUNCE_SCANS full frames after the first frame containing the key, plus 1 cycle.
  - Counter widths are sized for the parameters; no wrap occurs inside the legal range.
  - rst asserted mid-frame or mid-debounce returns everything to reset values on that edge. Scanning restarts at row 0 with a fresh div count.

Test Plan:
(SCAN_DIV=8, DEBOUNCE_SCANS=3; bench keypad model pulls column c low only while kp_row drives row r low for each pressed (r,c).)
1. Reset, no keys → all outputs at reset values; kp_row cycles 1110,1101,1011,0111 with 8 clocks each and repeats; key_valid never asserts.
2. Press (row2,col1) steady → exactly one key_valid pulse, 3 frames after first full containing frame; key_code=9; key_held=1; no further pulses over 10 more frames.
3. Bouncing (row0,col3): pressed in alternating frames for 6 frames → no key_valid; key_held=0.
4. Press codes 0 and 5 together for 4 frames → multi_key=1 and no key_valid. Then release 0 and keep 5 → multi_key=0, single key_valid with key_code=5.
5. After test 2 key release:
   - One empty frame then re-press → key_held stays 1, no new pulse.
   - Then 3 empty frames → key_held=0.
   - Then re-press code 9 → a new key_valid pulse.
6. Assert rst for 1 cycle during DEBOUNCE (cnt=2) → outputs at reset values on the next edge; kp_row=1110; a steady key needs a full 3 fresh frames to be accepted.
